pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush controller for the 5-stage RV32I pipeline. Merges per-stage stall requests into the
//  shared stall bus consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb, and sequences branch-mispredict
//  flushes: a flush raised while EX is frozen is held pending until EX may advance. Watchdog flags stuck stalls.
// PARAMETERS
//  ADDR_W  32  width of PC / redirect target
//  WDOG_W  16  watchdog counter width; hang at 2**WDOG_W-1 consecutive stalled cycles
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous, active-high reset
//  stallreq_if    in   1       IF waiting on memory port
//  stallreq_id    in   1       ID load-use hazard
//  stallreq_ex    in   1       EX multi-cycle op busy
//  stallreq_mem   in   1       MEM waiting on memory port
//  jmp_wrong_i    in   1       EX mispredict, valid same cycle as jmp_target_i
//  jmp_target_i   in   ADDR_W  correct PC for mispredicted jump
//  stall_o        out  6       [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; 1 = hold stage
//  flush_o        out  1       squash IF/ID and ID/EX this cycle (drives ex_jmp_wrong_i)
//  redirect_o     out  1       pc_reg loads target_o this cycle
//  target_o       out  ADDR_W  redirect PC
//  hang_o         out  1       sticky watchdog flag
// BEHAVIOUR
//  Reset: state=RUN, pend target=0, wdog=0; hang_o=0; outputs combinational, so with no requests
//   stall_o=6'b000000, flush_o=0, redirect_o=0, target_o=0 in reset cycle.
//  Stall merge (combinational, highest requesting stage wins): mem->6'b011111, ex->6'b001111,
//   id->6'b000111, if->6'b000011, none->6'b000000. WB never stalled.
//  States RUN, PEND, SQUASH (2-bit reg):
//   RUN: jmp_wrong_i & !stall_o[3] -> flush_o=redirect_o=1, target_o=jmp_target_i, next SQUASH.
//        jmp_wrong_i & stall_o[3]  -> latch jmp_target_i, no flush, next PEND.
//   PEND: jmp_wrong_i ignored; target_o=latched. When !stall_o[3]: flush_o=redirect_o=1, next SQUASH;
//        else stay.
//   SQUASH: one cycle; stallreq_if/stallreq_id masked (wrong-path), stallreq_ex/mem honoured; next RUN.
//        jmp_wrong_i here ignored (cannot be valid: EX holds a bubble).
//  Flush and stall never both assert stall_o[3]: flush_o=1 implies stall_o[3]=0.
//  redirect_o overrides stall_o[0] in pc_reg (PC loads target even if IF requested stall).
//  Watchdog: counts cycles with stall_o!=0, clears on any cycle with stall_o==0; on reaching all-ones
//   set hang_o (sticky until rst), counter saturates.
//  Reset mid-PEND: pending flush discarded, state=RUN.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: adds outputs perf_cycles_o, perf_stall_o, perf_flush_o (32 b each):
//   free-running cycle count, cycles with stall_o[0]=1, count of flush_o pulses; wrap at 2**32; zero on rst.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 stallreq_id=1 alone, 3 cycles -> stall_o=6'b000111 each cycle, flush_o=0, then 0 after release.
//  2 stallreq_if=1 and stallreq_mem=1 same cycle -> stall_o=6'b011111.
//  3 jmp_wrong_i=1, target=0x0000_1040, no stalls -> flush_o=redirect_o=1, target_o=0x1040 same cycle;
//    next cycle stallreq_id=1 -> stall_o=0 (SQUASH mask); following cycle RUN.
//  4 stallreq_ex=1 held 4 cycles, jmp_wrong_i pulse cycle 1 target=0x200 -> flush_o=0 cycles 1-4,
//    flush_o=1 and target_o=0x200 on first cycle stallreq_ex=0; exactly one flush pulse.
//  5 WDOG_W=4, stallreq_mem held 15 cycles -> hang_o=1 from cycle 15, stays 1 after release until rst.
//  6 rst asserted while in PEND -> next cycle state RUN, no flush_o pulse after rst release.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: stall merge, mispredict flush sequencing,
// stall watchdog. Optional performance counters when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WDOG_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              jmp_wrong_i,
  input  logic [ADDR_W-1:0] jmp_target_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] target_o,
  output logic              hang_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles_o,
  output logic [31:0]       perf_stall_o,
  output logic [31:0]       perf_flush_o
`endif
);

  typedef enum logic [1:0] {StRun, StPend, StSquash} state_e;

  state_e              state_q, state_d, cur_state;
  logic [ADDR_W-1:0]   pend_q, pend_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                hang_q, hang_d;
  logic                squash, req_if, req_id, ex_frozen;

  // Registers read as their reset values during the synchronous reset cycle.
  assign cur_state = rst ? StRun : state_q;
  assign squash    = (cur_state == StSquash);
  // IF/ID hold wrong-path instructions during the squash cycle.
  assign req_if    = stallreq_if & ~squash;
  assign req_id    = stallreq_id & ~squash;

  always_comb begin
    stall_o = 6'b000000;
    if (stallreq_mem)     stall_o = 6'b011111;
    else if (stallreq_ex) stall_o = 6'b001111;
    else if (req_id)      stall_o = 6'b000111;
    else if (req_if)      stall_o = 6'b000011;
  end

  assign ex_frozen = stall_o[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      pend_q  <= '0;
      wdog_q  <= '0;
      hang_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      wdog_q  <= wdog_d;
      hang_q  <= hang_d;
    end
  end

  always_comb begin
    state_d = cur_state;
    pend_d  = pend_q;
    case (cur_state)
      StRun: begin
        if (jmp_wrong_i) begin
          if (ex_frozen) begin
            state_d = StPend;
            pend_d  = jmp_target_i;
          end else begin
            state_d = StSquash;
          end
        end
      end
      StPend:   if (!ex_frozen) state_d = StSquash;
      StSquash: state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  always_comb begin
    flush_o  = 1'b0;
    target_o = rst ? '0 : pend_q;
    if (!rst) begin
      case (cur_state)
        StRun: begin
          if (jmp_wrong_i && !ex_frozen) begin
            flush_o  = 1'b1;
            target_o = jmp_target_i;
          end
        end
        StPend:  flush_o = !ex_frozen;
        default: flush_o = 1'b0;
      endcase
    end
  end

  assign redirect_o = flush_o;

  // Watchdog saturates at all-ones; hang is sticky until reset.
  always_comb begin
    wdog_d = wdog_q;
    if (stall_o == 6'b000000) wdog_d = '0;
    else if (wdog_q != {WDOG_W{1'b1}}) wdog_d = wdog_q + WDOG_W'(1);
    hang_d = hang_q | (wdog_d == {WDOG_W{1'b1}});
  end

  assign hang_o = hang_q & ~rst;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cyc_q, stl_q, fls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      stl_q <= '0;
      fls_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      stl_q <= stl_q + 32'(stall_o[0]);
      fls_q <= fls_q + 32'(flush_o);
    end
  end

  assign perf_cycles_o = cyc_q;
  assign perf_stall_o  = stl_q;
  assign perf_flush_o  = fls_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a flag-level reference model.
module tb_pipeline_ctrl;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WDOG_W = 4;
  localparam int          WDOG_MAX = (1 << WDOG_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic              jmp_wrong_i;
  logic [ADDR_W-1:0] jmp_target_i;
  logic [5:0]        stall_o;
  logic              flush_o, redirect_o, hang_o;
  logic [ADDR_W-1:0] target_o;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]       perf_cycles_o, perf_stall_o, perf_flush_o;
`endif

  pipeline_ctrl #(
    .ADDR_W(ADDR_W),
    .WDOG_W(WDOG_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .jmp_wrong_i  (jmp_wrong_i),
    .jmp_target_i (jmp_target_i),
    .stall_o      (stall_o),
    .flush_o      (flush_o),
    .redirect_o   (redirect_o),
    .target_o     (target_o),
    .hang_o       (hang_o)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_cycles_o(perf_cycles_o),
    .perf_stall_o (perf_stall_o),
    .perf_flush_o (perf_flush_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: a flush is pending, the previous cycle flushed, run length of stalls, hang.
  bit               m_pend   = 1'b0;
  bit               m_squash = 1'b0;
  bit               m_hang   = 1'b0;
  int               m_run    = 0;
  logic [ADDR_W-1:0] m_tgt   = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic i_f, input logic i_d, input logic e,
                      input logic m, input logic j, input logic [ADDR_W-1:0] t);
    logic [5:0]        exp_stall;
    logic              exp_flush, frozen, sq, start_pend;
    logic [ADDR_W-1:0] exp_tgt;
    rst = r; stallreq_if = i_f; stallreq_id = i_d; stallreq_ex = e; stallreq_mem = m;
    jmp_wrong_i = j; jmp_target_i = t;

    sq = !r && m_squash;
    if (m)                exp_stall = 6'b011111;
    else if (e)           exp_stall = 6'b001111;
    else if (i_d && !sq)  exp_stall = 6'b000111;
    else if (i_f && !sq)  exp_stall = 6'b000011;
    else                  exp_stall = 6'b000000;
    frozen     = exp_stall[3];
    exp_flush  = 1'b0;
    exp_tgt    = '0;
    start_pend = 1'b0;
    if (!r) begin
      if (m_pend) begin
        exp_flush = !frozen;
        exp_tgt   = m_tgt;
      end else if (!m_squash && j) begin
        exp_flush  = !frozen;
        exp_tgt    = t;
        start_pend = frozen;
      end
    end

    @(negedge clk);
    check_eq("stall", 64'(stall_o), 64'(exp_stall));
    check_eq("flush", 64'(flush_o), 64'(exp_flush));
    check_eq("redirect", 64'(redirect_o), 64'(exp_flush));
    check_eq("hang", 64'(hang_o), 64'(r ? 1'b0 : m_hang));
    if (r || exp_flush) check_eq("target", 64'(target_o), 64'(exp_tgt));

    @(posedge clk);
    if (r) begin
      m_pend = 1'b0; m_squash = 1'b0; m_hang = 1'b0; m_run = 0; m_tgt = '0;
    end else begin
      if (start_pend) m_tgt = t;
      m_pend   = m_pend ? frozen : start_pend;
      m_squash = exp_flush;
      m_run    = (exp_stall != 6'b000000) ? m_run + 1 : 0;
      if (m_run >= WDOG_MAX) m_hang = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    int mem_burst;
    logic [ADDR_W-1:0] rt;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle(1);

    // Load-use stall for three cycles, then release.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(1);
    // IF and MEM together: MEM wins.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    idle(1);

    // Immediate mispredict, then ID request masked during the squash cycle.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1040);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(1);

    // Mispredict while EX is busy: deferred until EX releases.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0200);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(3);

    // Watchdog: MEM held long enough to trip hang, which then sticks.
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle(1);

    // Reset while a flush is pending discards it.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0abc);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(3);

    mem_burst = 0;
    for (int c = 0; c < 3000; c++) begin
      rt = $urandom;
      if (mem_burst == 0 && $urandom_range(0, 99) == 0) mem_burst = $urandom_range(10, 20);
      if (mem_burst > 0) begin
        mem_burst--;
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1,
             1'($urandom_range(0, 3) == 0), rt);
      end else begin
        step(1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0), rt);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
